// File: rtl/qpsk_demapper.sv
// QPSK receive demapper: slices signed 3-bit I/Q symbols, undoes the differential
// coding on the I pair and serialises each 4-bit group in the order p3,p2,p1,p0.
module qpsk_demapper #(
  parameter logic INIT_I1 = 1'b1,
  parameter logic INIT_I2 = 1'b0,
  parameter int   ECNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic signed [2:0] Ik,
  input  logic signed [2:0] Qk,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              overrun,
  output logic [ECNT_W-1:0] erase_cnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nx;
  logic [1:0]        idx, idx_nx;
  logic [3:0]        sh, sh_nx;
  logic              serial_nx, bit_valid_nx, overrun_nx;
  logic              o1, o2, o1_nx, o2_nx;
  logic [ECNT_W-1:0] erase_nx;

  logic [1:0] r_bits, q_bits;
  logic       p0, p1;
  logic [3:0] group;
  logic       off_grid;
  logic       accept;

  // Nearest level in {-2,-1,1,2} as its Gray-coded bit pair; 0 resolves to +1.
  function automatic logic [1:0] slice(input logic [2:0] v);
    case (v)
      3'b100, 3'b101, 3'b110: slice = 2'b00;
      3'b111:                 slice = 2'b01;
      3'b000, 3'b001:         slice = 2'b11;
      default:                slice = 2'b10;
    endcase
  endfunction

  function automatic logic is_off_grid(input logic [2:0] v);
    is_off_grid = (v == 3'b100) || (v == 3'b101) || (v == 3'b000) || (v == 3'b011);
  endfunction

  always_comb begin
    r_bits = slice(Ik);
    q_bits = slice(Qk);
    // Equal reference bits keep the pair order; unequal ones swap it.
    if (o1 == o2) begin
      p0 = r_bits[1] ^ o1;
      p1 = r_bits[0] ^ o2;
    end else begin
      p1 = r_bits[1] ^ o1;
      p0 = r_bits[0] ^ o2;
    end
    group    = {q_bits[0], q_bits[1], p1, p0};
    off_grid = is_off_grid(Ik) || is_off_grid(Qk);
  end

  assign sym_ready = (state == IDLE) || ((state == SHIFT) && (idx == 2'd3));
  assign accept    = sym_valid && sym_ready;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    state_nx     = state;
    idx_nx       = idx;
    sh_nx        = sh;
    serial_nx    = serial_out;
    bit_valid_nx = bit_valid;
    o1_nx        = o1;
    o2_nx        = o2;
    erase_nx     = erase_cnt;
    overrun_nx   = overrun || (sym_valid && !sym_ready);

    if (state == SHIFT && idx != 2'd3) begin
      idx_nx    = idx + 2'd1;
      serial_nx = sh[3];
      sh_nx     = {sh[2:0], 1'b0};
    end else if (accept) begin
      state_nx     = SHIFT;
      idx_nx       = 2'd0;
      serial_nx    = group[3];
      sh_nx        = {group[2:0], 1'b0};
      bit_valid_nx = 1'b1;
      o1_nx        = r_bits[1];
      o2_nx        = r_bits[0];
      if (off_grid && (erase_cnt != {ECNT_W{1'b1}}))
        erase_nx = erase_cnt + ECNT_W'(1);
    end else begin
      state_nx     = IDLE;
      bit_valid_nx = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all registers sample together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      idx        <= 2'd0;
      sh         <= 4'd0;
      serial_out <= 1'b0;
      bit_valid  <= 1'b0;
      overrun    <= 1'b0;
      erase_cnt  <= '0;
      o1         <= INIT_I1;
      o2         <= INIT_I2;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      sh         <= sh_nx;
      serial_out <= serial_nx;
      bit_valid  <= bit_valid_nx;
      overrun    <= overrun_nx;
      erase_cnt  <= erase_nx;
      o1         <= o1_nx;
      o2         <= o2_nx;
    end
  end

endmodule

// File: doc/qpsk_demapper.md
Name: qpsk_demapper

Overview:
- Receive-side counterpart of the 4-bit-per-symbol differential mapper.
- Accepts signed 3-bit I/Q symbols and slices each to the nearest level in {-2,-1,1,2}.
- Undoes the differential coding on the I bit pair and demaps the Q bit pair.
- Serialises the recovered 4-bit group back to a 1-bit stream, in the same bit order the mapper's serial input used.

Parameters:
- INIT_I1, 1, reset value of the differential reference bit o1.
- INIT_I2, 0, reset value of the differential reference bit o2.
- ECNT_W, 8, width of the saturating erasure counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- Ik  input  3  signed received in-phase symbol.
- Qk  input  3  signed received quadrature symbol.
- sym_valid  input  1  Ik/Qk valid this cycle.
- sym_ready  output  1  block can accept a symbol this cycle.
- serial_out  output  1  recovered bit.
- bit_valid  output  1  serial_out holds a valid bit.
- overrun  output  1  sticky flag: sym_valid was seen while sym_ready was low.
- erase_cnt  output  ECNT_W  saturating count of accepted symbols with an off-grid component.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state=IDLE, bit index=0.
  - serial_out=0, bit_valid=0, overrun=0, erase_cnt=0.
  - o1=INIT_I1, o2=INIT_I2.
- Slicer (combinational, per component v):
  - v<=-2 -> bits 00; v=-1 -> 01; v=0 or v=1 -> 11; v>=2 -> 10.
  - Off-grid values are -4, -3, 0 and 3.
- I differential decode. Sliced I gives (r1,r2); reference bits are (o1,o2):
  - if o1==o2: p0=r1^o1, p1=r2^o2.
  - else: p1=r1^o1, p0=r2^o2.
  - (o1,o2) <= (r1,r2), only on an accepted symbol.
- Q demap. Sliced Q gives (q1,q2): p2=q1, p3=q2.
  - Qk=-2 -> p2p3=00; -1 -> 01; 1 -> 11; 2 -> 10.
- Handshake:
  - A symbol is accepted on a rising edge where sym_valid & sym_ready.
  - sym_ready = (state==IDLE) | (state==SHIFT & bit index==3). This is combinational from state only, never from sym_valid.
- FSM, IDLE:
  - bit_valid=0.
  - On accept: load shift register {p3,p2,p1,p0}, serial_out<=p3, bit_valid<=1, index<=0, go to SHIFT.
- FSM, SHIFT:
  - Each edge advances the index and presents p2, then p1, then p0. Output order is p3,p2,p1,p0.
  - At index 3 with an accept: load the new group, serial_out<=new p3, index<=0. The stream is gapless.
  - At index 3 with no accept: bit_valid<=0, go to IDLE.
- Latency: symbol accepted at edge N -> bits visible after edges N, N+1, N+2, N+3. Throughput is one symbol per 4 clocks.
- overrun:
  - Set on any edge with sym_valid & ~sym_ready. The symbol is dropped and the decoder state is unchanged.
  - Cleared only by reset.
- erase_cnt:
  - +1 per accepted symbol where Ik or Qk is off-grid. A symbol with both components off-grid counts once.
  - Saturates at all-ones. Sliced bits are still used.
- Reset mid-stream aborts the current group immediately. The next accepted symbol decodes against (INIT_I1, INIT_I2).

Test Plan:
- Reset, then accept (Ik=1,Qk=2) -> serial_out 0,1,0,1 with bit_valid high for 4 cycles; sym_ready high in IDLE and at the 4th bit.
- Back-to-back: (1,2) then (-2,-1) presented at the index-3 cycle -> 8 contiguous bits 0,1,0,1,1,0,1,1; bit_valid never drops.
- Loopback: random 4-bit groups through the mapper into this block, 1000 symbols -> the recovered bit stream equals the mapper input stream, including the leading differential reference (1,0).
- Offer a symbol while busy (index 1) -> symbol ignored, overrun=1 and sticky; the next legal symbol decodes against the unchanged (o1,o2).
- Off-grid: accept (Ik=0,Qk=3) -> sliced as (1,2), erase_cnt 0->1. With ECNT_W=2, 5 off-grid symbols -> erase_cnt=3.
- Assert RST_N low mid-group (index 2) -> bit_valid=0 and serial_out=0 immediately. After release, (1,2) again yields 0,1,0,1.
